alu_arbiter: RTL

Round-robin arbiter and sequencer sharing the single integer ALU between two requesters, e.g. port 0 = execute stage, port 1 = branch/address unit. It accepts one operation at a time over a valid/ready handshake and drives the ALU operand and function inputs from registers. It captures the ALU result and zero flag, then returns them to the granted requester over a valid/ready response channel.

---
 rtl/alu_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end that shares one combinational integer ALU
// between two requesters. One operation is in flight at a time:
// IDLE (arbitrate/accept) -> EXEC (ALU settles) -> RESP (hold result until taken).
//
// Handshake rule for both channels: a transfer happens on a rising edge where
// valid and ready are both high. A requester holds valid and its operands until
// it sees ready; the block holds resp_valid, resp_rd and resp_z until it sees
// resp_ready on the granted port.
module alu_arbiter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [XLEN-1:0]  req_rs1_0,
    input  logic [XLEN-1:0]  req_rs1_1,
    input  logic [XLEN-1:0]  req_rs2_0,
    input  logic [XLEN-1:0]  req_rs2_1,
    input  logic [2:0]       req_funct3_0,
    input  logic [2:0]       req_funct3_1,
    input  logic             req_funct7_0,
    input  logic             req_funct7_1,
    output logic [1:0]       resp_valid,
    input  logic [1:0]       resp_ready,
    output logic [XLEN-1:0]  resp_rd,
    output logic             resp_z,
    output logic [XLEN-1:0]  alu_rs1,
    output logic [XLEN-1:0]  alu_rs2,
    output logic [2:0]       alu_funct3,
    output logic             alu_funct7,
    input  logic [XLEN-1:0]  alu_rd,
    input  logic             alu_z,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_last_grant;
    logic              r_grant;
    logic [XLEN-1:0]   r_alu_rs1;
    logic [XLEN-1:0]   r_alu_rs2;
    logic [2:0]        r_alu_funct3;
    logic              r_alu_funct7;
    logic [XLEN-1:0]   r_resp_rd;
    logic              r_resp_z;
    logic [1:0]        r_resp_valid;
    logic              r_busy;
    logic [CNT_W-1:0]  r_op_count;

    logic              w_grant;
    logic [1:0]        w_req_ready;
    logic              w_accept;
    logic              w_resp_hs;

    // Arbitration: on a tie the port that did not win last time gets the grant;
    // a lone requester wins regardless of history. Ready only offered in IDLE
    // and never while reset is asserted.
    always_comb begin
        w_grant     = 1'b0;
        w_req_ready = 2'b00;
        if (req_valid == 2'b11) begin
            w_grant = ~r_last_grant;
        end else begin
            w_grant = req_valid[1];
        end
        if (rst_n && (r_state == S_IDLE) && (req_valid != 2'b00)) begin
            w_req_ready = w_grant ? 2'b10 : 2'b01;
        end
        w_accept  = (req_valid & w_req_ready) != 2'b00;
        w_resp_hs = (r_state == S_RESP) && resp_ready[r_grant];
    end

    // Sequencer: latch the winner's operation, give the ALU one cycle, capture
    // its result, then hold the response until the granted port takes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_alu_rs1    <= '0;
            r_alu_rs2    <= '0;
            r_alu_funct3 <= 3'd0;
            r_alu_funct7 <= 1'b0;
            r_resp_rd    <= '0;
            r_resp_z     <= 1'b0;
            r_resp_valid <= 2'b00;
            r_busy       <= 1'b0;
            r_op_count   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_alu_rs1    <= w_grant ? req_rs1_1    : req_rs1_0;
                        r_alu_rs2    <= w_grant ? req_rs2_1    : req_rs2_0;
                        r_alu_funct3 <= w_grant ? req_funct3_1 : req_funct3_0;
                        r_alu_funct7 <= w_grant ? req_funct7_1 : req_funct7_0;
                        r_last_grant <= w_grant;
                        r_grant      <= w_grant;
                        r_busy       <= 1'b1;
                        r_state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_resp_rd    <= alu_rd;
                    r_resp_z     <= alu_z;
                    r_resp_valid <= r_grant ? 2'b10 : 2'b01;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    if (w_resp_hs) begin
                        r_resp_valid <= 2'b00;
                        r_busy       <= 1'b0;
                        r_op_count   <= r_op_count + {{(CNT_W-1){1'b0}}, 1'b1};
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = w_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rd    = r_resp_rd;
    assign resp_z     = r_resp_z;
    assign alu_rs1    = r_alu_rs1;
    assign alu_rs2    = r_alu_rs2;
    assign alu_funct3 = r_alu_funct3;
    assign alu_funct7 = r_alu_funct7;
    assign busy       = r_busy;
    assign op_count   = r_op_count;

endmodule
